// File: rtl/saph_fpu_arbiter_if.sv
// rtl/saph_fpu_arbiter_if.sv - requester, response and FPU signal bundle for the FPU arbiter
interface saph_fpu_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_mode;
  logic [32*NREQ-1:0]   req_lhs;
  logic [32*NREQ-1:0]   req_rhs;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [32*NREQ-1:0]   resp_res;
  logic [NREQ-1:0]      resp_err;
  logic                 fpu_d_trig;
  logic [1:0]           fpu_d_mode;
  logic [31:0]          fpu_d_lhs;
  logic [31:0]          fpu_d_rhs;
  logic                 fpu_d_ready;
  logic [3:0]           fpu_has_modes;
  logic                 fpu_q_trig;
  logic [31:0]          fpu_q_res;
  logic                 seq_err;

  // Environment side: requesters plus the FPU itself
  modport master (
    output req_valid, req_mode, req_lhs, req_rhs, resp_ready,
    output fpu_d_ready, fpu_has_modes, fpu_q_trig, fpu_q_res,
    input  req_ready, resp_valid, resp_res, resp_err,
    input  fpu_d_trig, fpu_d_mode, fpu_d_lhs, fpu_d_rhs, seq_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_mode, req_lhs, req_rhs, resp_ready,
    input  fpu_d_ready, fpu_has_modes, fpu_q_trig, fpu_q_res,
    output req_ready, resp_valid, resp_res, resp_err,
    output fpu_d_trig, fpu_d_mode, fpu_d_lhs, fpu_d_rhs, seq_err
  );
endinterface

// File: rtl/saph_fpu_arbiter.sv
// rtl/saph_fpu_arbiter.sv - round-robin arbiter sharing one fixed-latency FPU among NREQ requesters
module saph_fpu_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  saph_fpu_arbiter_if.slave bus
);
  localparam int             IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);

  logic [NREQ-1:0]           busy_q, busy_d;
  logic [NREQ-1:0]           rv_q, rv_d;
  logic [NREQ-1:0]           err_q, err_d;
  logic [NREQ-1:0][31:0]     res_q, res_d;
  logic [IDW-1:0]            last_grant_q, last_grant_d;
  logic                      seq_err_q, seq_err_d;

  logic [1:0]                mode_a [NREQ];
  logic [31:0]               lhs_a  [NREQ];
  logic [31:0]               rhs_a  [NREQ];
  logic [NREQ-1:0]           eligible;
  logic                      grant_vld;
  logic [IDW-1:0]            grant_id;
  logic [IDW:0]              cand;
  logic [1:0]                g_mode;
  logic                      supported;
  logic                      issue;
  logic                      exit_vld;
  logic [IDW-1:0]            exit_id;

  // Split the flat request buses into per-requester fields
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      mode_a[i] = bus.req_mode[2*i +: 2];
      lhs_a[i]  = bus.req_lhs[32*i +: 32];
      rhs_a[i]  = bus.req_rhs[32*i +: 32];
    end
  end

  // Round-robin search beginning one past the last granted requester
  always_comb begin
    eligible  = bus.req_valid & ~busy_q & {NREQ{bus.fpu_d_ready}};
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!grant_vld && eligible[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[IDW-1:0];
      end
    end
  end

  // Accept the winner and forward its operation when the FPU supports the mode
  always_comb begin
    g_mode         = mode_a[grant_id];
    supported      = bus.fpu_has_modes[g_mode];
    issue          = grant_vld & supported & rst_n;
    bus.req_ready  = '0;
    if (grant_vld && rst_n) begin
      bus.req_ready[grant_id] = 1'b1;
    end
    bus.fpu_d_trig = issue;
    bus.fpu_d_mode = g_mode;
    bus.fpu_d_lhs  = lhs_a[grant_id];
    bus.fpu_d_rhs  = rhs_a[grant_id];
  end

  generate
    if (LATENCY == 0) begin : g_tag_comb
      assign exit_vld = issue;
      assign exit_id  = grant_id;
    end else begin : g_tag_pipe
      logic [LATENCY-1:0]          tag_vld_q;
      logic [LATENCY-1:0][IDW-1:0] tag_id_q;

      // Delay the issue tag so it leaves exactly when the FPU result is due
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q <= '0;
          tag_id_q  <= '0;
        end else begin
          tag_vld_q[0] <= issue;
          tag_id_q[0]  <= grant_id;
          for (int s = 1; s < LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_id_q[s]  <= tag_id_q[s-1];
          end
        end
      end

      assign exit_vld = tag_vld_q[LATENCY-1];
      assign exit_id  = tag_id_q[LATENCY-1];
    end
  endgenerate

  // Busy/response bookkeeping; busy guarantees a buffer is never written while handshaking
  always_comb begin
    busy_d       = busy_q;
    rv_d         = rv_q;
    err_d        = err_q;
    res_d        = res_q;
    last_grant_d = last_grant_q;
    seq_err_d    = seq_err_q;
    for (int i = 0; i < NREQ; i++) begin
      if (rv_q[i] && bus.resp_ready[i]) begin
        rv_d[i]   = 1'b0;
        busy_d[i] = 1'b0;
      end
    end
    if (grant_vld) begin
      busy_d[grant_id] = 1'b1;
      last_grant_d     = grant_id;
      if (!supported) begin
        rv_d[grant_id]  = 1'b1;
        err_d[grant_id] = 1'b1;
        res_d[grant_id] = '0;
      end
    end
    if (bus.fpu_q_trig != exit_vld) begin
      seq_err_d = 1'b1;
    end else if (exit_vld) begin
      rv_d[exit_id]  = 1'b1;
      err_d[exit_id] = 1'b0;
      res_d[exit_id] = bus.fpu_q_res;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      rv_q         <= '0;
      err_q        <= '0;
      res_q        <= '0;
      last_grant_q <= IDW'(NREQ-1);
      seq_err_q    <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      rv_q         <= rv_d;
      err_q        <= err_d;
      res_q        <= res_d;
      last_grant_q <= last_grant_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign bus.resp_valid = rv_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_res   = res_q;
  assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// tb/tb_saph_fpu_arbiter.sv - randomized and directed checks of saph_fpu_arbiter against a cycle model
module tb_saph_fpu_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  saph_fpu_arbiter_if #(.NREQ(NREQ)) bus ();

  saph_fpu_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state
  int           m_last;
  bit           m_busy [NREQ];
  bit           m_rv   [NREQ];
  bit           m_err  [NREQ];
  logic [31:0]  m_res  [NREQ];
  bit           p_act  [NREQ];
  int           p_due  [NREQ];
  logic [31:0]  p_res  [NREQ];
  bit           p_err  [NREQ];
  bit           m_seq;
  bit           hist   [16];
  int           cyc;
  int           g_obs;
  bit           inject_trig;
  logic [31:0]  saved;

  // FPU stand-in: issued operations return LAT cycles later
  int           fq_due [$];
  logic [31:0]  fq_res [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fpu_fn(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m == 2'd0 && a == 32'h3f80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    case (m)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    bus.req_mode[2*i +: 2] = m;
    bus.req_lhs[32*i +: 32] = a;
    bus.req_rhs[32*i +: 32] = b;
  endtask

  task automatic model_clear();
    m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      m_busy[i] = 0; m_rv[i] = 0; m_err[i] = 0; m_res[i] = '0; p_act[i] = 0;
    end
    for (int i = 0; i < 16; i++) hist[i] = 0;
    m_seq = 0;
    cyc = 0;
    fq_due.delete();
    fq_res.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_fpu_d_trig", bus.fpu_d_trig, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock cycle: present FPU returns, compare against the model, advance the model
  task automatic step();
    int g;
    int idx;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] rv_vec;
    bit sup;
    bit exp_exit;
    logic [1:0] md;
    logic [31:0] a, b;
    for (int i = 0; i < NREQ; i++) begin
      if (p_act[i] && p_due[i] == cyc) begin
        m_rv[i] = 1; m_res[i] = p_res[i]; m_err[i] = p_err[i]; p_act[i] = 0;
      end
    end
    bus.fpu_q_trig = 1'b0;
    bus.fpu_q_res  = $urandom;
    if (fq_due.size() > 0 && fq_due[0] == cyc) begin
      bus.fpu_q_trig = 1'b1;
      bus.fpu_q_res  = fq_res[0];
      void'(fq_due.pop_front());
      void'(fq_res.pop_front());
    end
    if (inject_trig) bus.fpu_q_trig = 1'b1;
    #1;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_last + k) % NREQ;
      if (g < 0 && bus.req_valid[idx] && !m_busy[idx] && bus.fpu_d_ready) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    g_obs = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g_obs = i;
    chk("req_ready", bus.req_ready, exp_rdy);
    sup = 0; md = '0; a = '0; b = '0;
    if (g >= 0) begin
      md  = bus.req_mode[2*g +: 2];
      a   = bus.req_lhs[32*g +: 32];
      b   = bus.req_rhs[32*g +: 32];
      sup = bus.fpu_has_modes[md];
    end
    chk("fpu_d_trig", bus.fpu_d_trig, sup);
    if (sup) begin
      chk("fpu_d_mode", bus.fpu_d_mode, md);
      chk("fpu_d_lhs", bus.fpu_d_lhs, a);
      chk("fpu_d_rhs", bus.fpu_d_rhs, b);
    end
    for (int i = 0; i < NREQ; i++) rv_vec[i] = m_rv[i];
    chk("resp_valid", bus.resp_valid, rv_vec);
    for (int i = 0; i < NREQ; i++) begin
      if (m_rv[i]) begin
        chk("resp_res", bus.resp_res[32*i +: 32], m_res[i]);
        chk("resp_err", bus.resp_err[i], m_err[i]);
      end
    end
    chk("seq_err", bus.seq_err, m_seq);
    for (int i = 0; i < NREQ; i++) begin
      if (m_rv[i] && bus.resp_ready[i]) begin m_rv[i] = 0; m_busy[i] = 0; end
    end
    if (g >= 0) begin
      m_busy[g] = 1; m_last = g; p_act[g] = 1;
      if (sup) begin p_due[g] = cyc + LAT + 1; p_res[g] = fpu_fn(md, a, b); p_err[g] = 0; end
      else     begin p_due[g] = cyc + 1;       p_res[g] = '0;               p_err[g] = 1; end
    end
    if (bus.fpu_d_trig) begin
      fq_due.push_back(cyc + LAT);
      fq_res.push_back(fpu_fn(bus.fpu_d_mode, bus.fpu_d_lhs, bus.fpu_d_rhs));
    end
    exp_exit = (cyc >= LAT) ? hist[(cyc - LAT) % 16] : 1'b0;
    if (bus.fpu_q_trig != exp_exit) m_seq = 1;
    hist[cyc % 16] = sup;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    repeat (6) step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '1; bus.req_mode = '0; bus.req_lhs = '0; bus.req_rhs = '0;
    bus.resp_ready = '0; bus.fpu_d_ready = 1'b1; bus.fpu_has_modes = 4'hF;
    bus.fpu_q_trig = 1'b0; bus.fpu_q_res = '0;
    inject_trig = 0;
    model_clear();
    @(negedge clk);
    do_reset(3);

    // All four requesting, results always accepted: 0,1,2,3 then 0 again after its handshake
    bus.req_valid = '1; bus.resp_ready = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 32'(i + 1), 32'(i * 7));
    for (int k = 0; k < 12; k++) begin
      step();
      if (k < 4)  chk("rr_order", g_obs, k);
      if (k == 4) chk("regrant0_after_resp", g_obs, 0);
    end
    drain();

    // Requester 2 adds 1.0 + 2.0
    bus.resp_ready = '0;
    bus.req_valid = 4'b0100;
    set_req(2, 2'd0, 32'h3f80_0000, 32'h4000_0000);
    step();
    chk("add_grant", g_obs, 2);
    bus.req_valid = '0;
    step();
    chk("add_not_early", bus.resp_valid[2], 0);
    step();
    chk("add_resp_valid", bus.resp_valid[2], 1);
    chk("add_resp_res", bus.resp_res[95:64], 32'h4040_0000);
    drain();

    // Division unsupported by the FPU
    bus.fpu_has_modes = 4'b0011;
    bus.resp_ready = '0;
    bus.req_valid = 4'b0010;
    set_req(1, 2'd3, 32'h1234_5678, 32'h9abc_def0);
    step();
    chk("div_resp_valid", bus.resp_valid[1], 1);
    chk("div_resp_err", bus.resp_err[1], 1);
    chk("div_resp_res", bus.resp_res[63:32], 0);
    drain();
    bus.fpu_has_modes = 4'hF;

    // Requester 3 held off by resp_ready low
    bus.resp_ready = 4'b0111;
    bus.req_valid = 4'b1000;
    set_req(3, 2'd2, 32'h0000_0321, 32'h0000_0011);
    repeat (3) step();
    chk("hold_resp_valid", bus.resp_valid[3], 1);
    saved = bus.resp_res[127:96];
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_resp_res", bus.resp_res[127:96], saved);
      chk("hold_req_ready3", bus.req_ready[3], 0);
    end
    drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = NREQ'($urandom);
      bus.resp_ready = NREQ'($urandom);
      bus.fpu_d_ready = ($urandom_range(0, 3) != 0);
      bus.fpu_has_modes = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_req(i, 2'($urandom_range(0, 3)), $urandom, $urandom);
      step();
    end
    bus.fpu_d_ready = 1'b1;
    bus.fpu_has_modes = 4'hF;
    drain();

    // Reset with operations outstanding
    bus.resp_ready = '0;
    bus.req_valid = 4'b0001;
    set_req(0, 2'd1, 32'd50, 32'd8);
    step();
    bus.req_valid = 4'b0010;
    set_req(1, 2'd2, 32'd6, 32'd9);
    step();
    bus.req_valid = '0;
    step();
    chk("pre_rst_resp_valid0", bus.resp_valid[0], 1);
    bus.req_valid = '1;
    do_reset(2);
    bus.resp_ready = '1;
    step();
    chk("post_rst_first_grant", g_obs, 0);
    drain();

    // Spurious FPU return
    inject_trig = 1;
    step();
    inject_trig = 0;
    chk("seq_err_set", bus.seq_err, 1);
    repeat (5) step();
    chk("seq_err_sticky", bus.seq_err, 1);
    do_reset(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/saph_fpu_arbiter.md
SAPH_FPU_ARBITER -- requirements
Module: saph_fpu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 2, fixed FPU latency in cycles (0..4).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 SHALL have port clk  in  1  core clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester operation valid.
REQ-007 SHALL have port req_ready  out  NREQ  per-requester accept, at most one bit high per cycle.
REQ-008 SHALL have port req_mode  in  2*NREQ  per-requester mode: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have ports req_lhs and req_rhs  in  32*NREQ  per-requester operands.
REQ-010 SHALL have port resp_valid  out  NREQ  per-requester result valid.
REQ-011 SHALL have port resp_ready  in  NREQ  per-requester result accept.
REQ-012 SHALL have port resp_res  out  32*NREQ  per-requester result.
REQ-013 SHALL have port resp_err  out  NREQ  per-requester flag: unsupported mode, result undefined.
REQ-014 SHALL have ports fpu_d_trig, fpu_d_mode[1:0], fpu_d_lhs[31:0], fpu_d_rhs[31:0]  out  FPU issue.
REQ-015 SHALL have ports fpu_d_ready  in  1, fpu_has_modes  in  4, fpu_q_trig  in  1, fpu_q_res  in  32.
REQ-016 SHALL have port seq_err  out  1  sticky FPU sequencing error.

Function
REQ-017 SHALL hold, per requester, a busy flag: set on req handshake, cleared on resp handshake.
REQ-018 SHALL treat requester i as eligible when req_valid[i] & ~busy[i] & fpu_d_ready.
REQ-019 SHALL grant one eligible requester per cycle, round-robin starting at last_grant+1 and wrapping NREQ-1 -> 0.
REQ-020 SHALL update last_grant only on a grant; no eligible requester leaves it unchanged.
REQ-021 SHALL drive req_ready[g]=1 combinationally for the granted requester g only.
REQ-022 SHALL, on a grant with supported mode (fpu_has_modes[req_mode] = 1), drive fpu_d_trig=1 and the operands/mode of g in the same cycle.
REQ-023 SHALL drive fpu_d_trig=0 when there is no grant; data outputs are then don't-care.
REQ-024 SHALL, on a grant with unsupported mode, keep fpu_d_trig=0 and load g's result buffer the next cycle with resp_err=1, resp_res=0.
REQ-025 SHALL carry a tag {valid, id} through a LATENCY-stage shift register, so the tag exits exactly when the FPU result is due.
REQ-026 SHALL, for LATENCY=0, route the tag combinationally.
REQ-027 SHALL, when fpu_q_trig=1 and the exiting tag is valid, write fpu_q_res into buffer[id] with resp_err=0 and set resp_valid[id] the next cycle.
REQ-028 SHALL, when fpu_q_trig differs from the exiting tag valid, set seq_err=1 until reset and drop the result.
REQ-029 SHALL hold resp_valid[i], resp_res[i] and resp_err[i] stable until resp_ready[i]; the handshake clears resp_valid[i] and busy[i].
REQ-030 SHALL allow a new grant to requester i in the cycle after its resp handshake, never in the same cycle.
REQ-031 SHALL guarantee that buffer write and resp handshake never coincide for one requester, because busy allows at most one outstanding operation.
REQ-032 SHALL give end-to-end latency from req handshake to resp_valid of LATENCY+1 cycles, or 1 cycle for an unsupported mode.
REQ-033 SHALL sustain throughput of one issue per cycle across distinct requesters.

Reset
REQ-034 SHALL, on rst_n low, asynchronously clear busy, resp_valid, resp_err, resp_res, all tag valids and seq_err, and set last_grant=NREQ-1.
REQ-035 SHALL, in reset, force req_ready=0 and fpu_d_trig=0.
REQ-036 SHALL, on reset mid-operation, discard in-flight tags; FPU results returning after reset release set seq_err.

Verification
REQ-037 SHALL verify: all four req_valid=1 continuously, resp_ready=1, LATENCY=2 -> grants 0,1,2,3 on consecutive cycles; requester 0 is not regranted until its resp handshake.
REQ-038 SHALL verify: requester 2 issues add 1.0+2.0 -> fpu_d_trig in the same cycle; resp_valid[2]=1 with resp_res=0x40400000 3 cycles later.
REQ-039 SHALL verify: fpu_has_modes=0011, requester 1 requests div -> no fpu_d_trig; resp_valid[1]=1 and resp_err[1]=1 next cycle.
REQ-040 SHALL verify: resp_ready[3]=0 for 10 cycles -> resp_res[3] stable and req_ready[3] low despite req_valid[3]=1.
REQ-041 SHALL verify: fpu_q_trig pulsed with no issued operation -> seq_err=1 next cycle, remaining high until rst_n low.
REQ-042 SHALL verify: rst_n low with 2 operations in flight -> all resp_valid=0 immediately; after release, requester 0 receives the first grant.
